// File: rtl/telemetry_check_pkg.sv
// rtl/telemetry_check_pkg.sv - shared constants, LED state encoding and counter helper for the telemetry checker
// Purpose: packet field positions, LED FSM state type and the statistics
//          increment helper used by every telemetry_check_* file.
// Ports:   none (package).
package telemetry_check_pkg;

    localparam int ID_MSB = 83;
    localparam int ID_LSB = 80;
    localparam int PKT_W  = 88;

    typedef enum logic [1:0] {
        DOWN   = 2'd0,
        ARMING = 2'd1,
        UP     = 2'd2
    } led_state_t;

    // Statistics increment: holds at all-ones when sat is set, wraps otherwise.
    function automatic logic [31:0] cnt_inc(input logic [31:0] v, input logic sat);
        if (sat && (v == 32'hffff_ffff)) begin
            return v;
        end
        return v + 32'd1;
    endfunction

endpackage

// File: rtl/telemetry_check_multi_if.sv
// rtl/telemetry_check_multi_if.sv - unpacked telemetry packet bus
// Purpose: carries one telemetry packet per cycle from the packet source
//          to the checker.
// Ports:   packet_data  [87:0] packet, [83:80] stream id, low bits counter
//          packet_valid        single-cycle qualifier for packet_data
//          modport master drives the bus, modport slave observes it.
interface telemetry_check_multi_if;
    import telemetry_check_pkg::*;

    logic [PKT_W-1:0] packet_data;
    logic             packet_valid;

    modport master (output packet_data, output packet_valid);
    modport slave  (input  packet_data, input  packet_valid);

endinterface

// File: rtl/telemetry_stream_check.sv
// rtl/telemetry_stream_check.sv - per-stream counter checker and statistics
// Purpose: tracks the expected counter value for one telemetry stream,
//          flags match/mismatch for the packet presented this cycle and
//          keeps the stream's packet and mismatch counts.
// Ports:   clk_256M, rst_n      clock, asynchronous active-low reset
//          hit                  a valid packet for this stream is present
//          cnt                  counter field of that packet
//          reset_counters       synchronous clear of the counts only
//          seen                 stream has been seeded by its first packet
//          pkt_count, mis_count packet / mismatch statistics
//          match, mismatch      combinational strobes for the current packet
module telemetry_stream_check
    import telemetry_check_pkg::*;
#(
    parameter int g_cnt_width = 10,
    parameter bit g_saturate  = 1'b1
) (
    input  logic                   clk_256M,
    input  logic                   rst_n,
    input  logic                   hit,
    input  logic [g_cnt_width-1:0] cnt,
    input  logic                   reset_counters,
    output logic                   seen,
    output logic [31:0]            pkt_count,
    output logic [31:0]            mis_count,
    output logic                   match,
    output logic                   mismatch
);

    logic [g_cnt_width-1:0] expected;

    // The first packet on an unseeded stream is accepted as good whatever
    // its value; after that the counter must equal the previous value + 1.
    assign match    = hit && (!seen || (cnt == expected));
    assign mismatch = hit && seen && (cnt != expected);

    always_ff @(posedge clk_256M or negedge rst_n) begin
        if (!rst_n) begin
            expected  <= '0;
            seen      <= 1'b0;
            pkt_count <= '0;
            mis_count <= '0;
        end else begin
            // Reload from the received value on every packet so a single
            // dropped packet costs exactly one mismatch.
            if (hit) begin
                seen     <= 1'b1;
                expected <= cnt + g_cnt_width'(1);
            end
            if (reset_counters) begin
                pkt_count <= '0;
                mis_count <= '0;
            end else if (hit) begin
                pkt_count <= cnt_inc(pkt_count, g_saturate);
                if (mismatch) begin
                    mis_count <= cnt_inc(mis_count, g_saturate);
                end
            end
        end
    end

endmodule

// File: rtl/telemetry_check_multi.sv
// rtl/telemetry_check_multi.sv - multi-stream telemetry test-counter checker
// Purpose: checks incrementing test counters on up to 16 telemetry streams
//          (selected by the packet stream id), keeps global and per-stream
//          statistics and drives the link/okay LEDs.
// Ports:   clk_256M, rst_n       clock, asynchronous active-low reset
//          pkt                   packet bus (slave)
//          reset_counters        synchronous clear of all statistics
//          stat_sel              stream index for sel_packets / sel_mismatch
//          total_packets         all valid packets
//          checked_packets       valid packets on enabled streams
//          mismatch_packets      sum of per-stream mismatch counts
//          sel_packets           checked packets on stream stat_sel
//          sel_mismatch          mismatches on stream stat_sel
//          stream_seen           bit n = stream n seeded
//          okay_led              long-streak good indicator
//          link_count_okay       per-packet good indicator
module telemetry_check_multi
    import telemetry_check_pkg::*;
#(
    parameter logic [15:0] g_stream_mask = 16'h2000,
    parameter int          g_cnt_width   = 10,
    parameter logic [19:0] g_match_cnt   = 20'h4ffff,
    parameter logic [15:0] g_timeout_cnt = 16'hffff,
    parameter bit          g_saturate    = 1'b1
) (
    input  logic                   clk_256M,
    input  logic                   rst_n,
    telemetry_check_multi_if.slave pkt,
    input  logic                   reset_counters,
    input  logic [3:0]             stat_sel,
    output logic [31:0]            total_packets,
    output logic [31:0]            checked_packets,
    output logic [31:0]            mismatch_packets,
    output logic [31:0]            sel_packets,
    output logic [31:0]            sel_mismatch,
    output logic [15:0]            stream_seen,
    output logic                   okay_led,
    output logic                   link_count_okay
);

    logic [3:0]             pkt_id;
    logic [g_cnt_width-1:0] pkt_cnt;
    logic                   enabled_hit;
    logic                   unused_bits;

    logic [15:0] s_match;
    logic [15:0] s_mismatch;
    logic [31:0] s_pkt [16];
    logic [31:0] s_mis [16];

    logic        match_r;
    logic        mismatch_r;
    logic [15:0] idle_cnt;
    logic        timeout;

    logic [35:0] mis_sum_wide;
    logic [31:0] mis_sum_sat;

    led_state_t  state, state_nxt;
    logic [19:0] match_cnt, match_cnt_nxt;
    logic [19:0] match_inc;
    logic        link_nxt;

    assign pkt_id      = pkt.packet_data[ID_MSB:ID_LSB];
    assign pkt_cnt     = pkt.packet_data[g_cnt_width-1:0];
    assign enabled_hit = pkt.packet_valid && g_stream_mask[pkt_id];
    // Most packet payload bits are not looked at by this block.
    assign unused_bits = ^pkt.packet_data;

    // One checker per enabled stream; disabled ids tie off to zero so the
    // statistics mux and adder see constant inputs for them.
    for (genvar n = 0; n < 16; n++) begin : g_stream
        if (g_stream_mask[n]) begin : g_on
            telemetry_stream_check #(
                .g_cnt_width (g_cnt_width),
                .g_saturate  (g_saturate)
            ) u_chk (
                .clk_256M       (clk_256M),
                .rst_n          (rst_n),
                .hit            (pkt.packet_valid && (pkt_id == 4'(n))),
                .cnt            (pkt_cnt),
                .reset_counters (reset_counters),
                .seen           (stream_seen[n]),
                .pkt_count      (s_pkt[n]),
                .mis_count      (s_mis[n]),
                .match          (s_match[n]),
                .mismatch       (s_mismatch[n])
            );
        end else begin : g_off
            assign stream_seen[n] = 1'b0;
            assign s_pkt[n]       = '0;
            assign s_mis[n]       = '0;
            assign s_match[n]     = 1'b0;
            assign s_mismatch[n]  = 1'b0;
        end
    end

    // Sixteen 32-bit counts need four guard bits before saturating.
    always_comb begin
        mis_sum_wide = '0;
        for (int n = 0; n < 16; n++) begin
            mis_sum_wide = mis_sum_wide + {4'd0, s_mis[n]};
        end
    end

    assign mis_sum_sat = (g_saturate && (mis_sum_wide[35:32] != 4'd0))
                       ? 32'hffff_ffff : mis_sum_wide[31:0];

    always_ff @(posedge clk_256M or negedge rst_n) begin
        if (!rst_n) begin
            total_packets    <= '0;
            checked_packets  <= '0;
            mismatch_packets <= '0;
            sel_packets      <= '0;
            sel_mismatch     <= '0;
            match_r          <= 1'b0;
            mismatch_r       <= 1'b0;
            idle_cnt         <= '0;
        end else begin
            match_r    <= |s_match;
            mismatch_r <= |s_mismatch;
            // Any valid packet, enabled or not, proves the link is alive.
            idle_cnt   <= pkt.packet_valid ? 16'd0 : idle_cnt + 16'd1;
            if (reset_counters) begin
                total_packets    <= '0;
                checked_packets  <= '0;
                mismatch_packets <= '0;
                sel_packets      <= '0;
                sel_mismatch     <= '0;
            end else begin
                if (pkt.packet_valid) begin
                    total_packets <= cnt_inc(total_packets, g_saturate);
                end
                if (enabled_hit) begin
                    checked_packets <= cnt_inc(checked_packets, g_saturate);
                end
                mismatch_packets <= mis_sum_sat;
                sel_packets      <= s_pkt[stat_sel];
                sel_mismatch     <= s_mis[stat_sel];
            end
        end
    end

    assign timeout   = (idle_cnt == g_timeout_cnt);
    assign match_inc = match_cnt + 20'd1;

    always_ff @(posedge clk_256M or negedge rst_n) begin
        if (!rst_n) begin
            state           <= DOWN;
            match_cnt       <= '0;
            link_count_okay <= 1'b0;
        end else begin
            state           <= state_nxt;
            match_cnt       <= match_cnt_nxt;
            link_count_okay <= link_nxt;
        end
    end

    // A bad packet or a stalled link always wins over a good packet.
    always_comb begin
        state_nxt     = state;
        match_cnt_nxt = match_cnt;
        link_nxt      = link_count_okay;
        if (timeout || mismatch_r) begin
            state_nxt     = DOWN;
            match_cnt_nxt = '0;
            link_nxt      = 1'b0;
        end else if (match_r) begin
            link_nxt = 1'b1;
            case (state)
                DOWN: begin
                    state_nxt     = ARMING;
                    match_cnt_nxt = 20'd1;
                end
                ARMING: begin
                    match_cnt_nxt = match_inc;
                    if (match_inc >= g_match_cnt) begin
                        state_nxt = UP;
                    end
                end
                default: begin
                    state_nxt = UP;
                end
            endcase
        end
    end

    assign okay_led = (state == UP);

endmodule

// File: tb/tb_telemetry_check_multi.sv
// tb/tb_telemetry_check_multi.sv - self-checking bench for telemetry_check_multi
module tb_telemetry_check_multi;

    localparam logic [15:0] MASK  = 16'h2009;
    localparam int          CW    = 10;
    localparam logic [19:0] MATCH = 20'd4;
    localparam logic [15:0] TMO   = 16'd16;

    logic        clk_256M = 1'b0;
    logic        rst_n = 1'b0;
    logic        reset_counters = 1'b0;
    logic [3:0]  stat_sel = 4'd0;
    logic [31:0] total_packets, checked_packets, mismatch_packets;
    logic [31:0] sel_packets, sel_mismatch;
    logic [15:0] stream_seen;
    logic        okay_led, link_count_okay;

    telemetry_check_multi_if bus ();

    always #2 clk_256M = ~clk_256M;

    telemetry_check_multi #(
        .g_stream_mask (MASK),
        .g_cnt_width   (CW),
        .g_match_cnt   (MATCH),
        .g_timeout_cnt (TMO),
        .g_saturate    (1'b1)
    ) dut (
        .clk_256M         (clk_256M),
        .rst_n            (rst_n),
        .pkt              (bus),
        .reset_counters   (reset_counters),
        .stat_sel         (stat_sel),
        .total_packets    (total_packets),
        .checked_packets  (checked_packets),
        .mismatch_packets (mismatch_packets),
        .sel_packets      (sel_packets),
        .sel_mismatch     (sel_mismatch),
        .stream_seen      (stream_seen),
        .okay_led         (okay_led),
        .link_count_okay  (link_count_okay)
    );

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural reference: statistics as plain arrays, LED behaviour as
    // a streak of consecutive good checked packets.
    bit [15:0]   mask_v = MASK;
    bit [31:0]   m_total = 0, m_checked = 0, m_sum = 0, m_sel_pkt = 0, m_sel_mis = 0;
    bit [31:0]   m_pkt [16];
    bit [31:0]   m_mis [16];
    bit [CW-1:0] m_exp [16];
    bit [15:0]   m_seen = 0;
    bit [15:0]   m_idle = 0;
    int          streak = 0;
    bit          m_link = 0;
    bit          pend_good = 0, pend_bad = 0;

    longint      mv_s;
    bit [31:0]   mv_sum, mv_sp, mv_sm;
    bit [3:0]    mv_id;
    bit [CW-1:0] mv_c;
    bit          mv_tmo;

    function automatic bit [31:0] inc32(input bit [31:0] v);
        return (v == 32'hffff_ffff) ? v : v + 32'd1;
    endfunction

    initial begin
        for (int n = 0; n < 16; n++) begin
            m_pkt[n] = 0; m_mis[n] = 0; m_exp[n] = 0;
        end
    end

    always @(posedge clk_256M or negedge rst_n) begin
        if (!rst_n) begin
            m_total = 0; m_checked = 0; m_sum = 0; m_sel_pkt = 0; m_sel_mis = 0;
            for (int n = 0; n < 16; n++) begin
                m_pkt[n] = 0; m_mis[n] = 0; m_exp[n] = 0;
            end
            m_seen = 0; m_idle = 0; streak = 0; m_link = 0;
            pend_good = 0; pend_bad = 0;
        end else begin
            mv_s = 0;
            for (int n = 0; n < 16; n++) mv_s += longint'(m_mis[n]);
            mv_sum = (mv_s > 64'h0000_0000_ffff_ffff) ? 32'hffff_ffff : mv_s[31:0];
            mv_sp  = m_pkt[stat_sel];
            mv_sm  = m_mis[stat_sel];
            // Outcome of the previous packet reaches the LEDs now.
            mv_tmo = (m_idle == TMO);
            if (mv_tmo || pend_bad) begin
                streak = 0; m_link = 0;
            end else if (pend_good) begin
                streak++; m_link = 1;
            end
            pend_good = 0; pend_bad = 0;
            m_idle = bus.packet_valid ? 16'd0 : m_idle + 16'd1;
            if (bus.packet_valid) begin
                mv_id   = bus.packet_data[83:80];
                mv_c    = bus.packet_data[CW-1:0];
                m_total = inc32(m_total);
                if (mask_v[mv_id]) begin
                    m_checked    = inc32(m_checked);
                    m_pkt[mv_id] = inc32(m_pkt[mv_id]);
                    if (m_seen[mv_id] && (mv_c != m_exp[mv_id])) begin
                        m_mis[mv_id] = inc32(m_mis[mv_id]);
                        pend_bad = 1;
                    end else begin
                        pend_good = 1;
                    end
                    m_seen[mv_id] = 1'b1;
                    m_exp[mv_id]  = mv_c + 1'b1;
                end
            end
            if (reset_counters) begin
                m_total = 0; m_checked = 0;
                for (int n = 0; n < 16; n++) begin
                    m_pkt[n] = 0; m_mis[n] = 0;
                end
                mv_sum = 0; mv_sp = 0; mv_sm = 0;
            end
            m_sum = mv_sum; m_sel_pkt = mv_sp; m_sel_mis = mv_sm;
        end
    end

    always @(negedge clk_256M) begin
        if (chk_en) begin
            chk("total_packets", total_packets, m_total);
            chk("checked_packets", checked_packets, m_checked);
            chk("mismatch_packets", mismatch_packets, m_sum);
            chk("sel_packets", sel_packets, m_sel_pkt);
            chk("sel_mismatch", sel_mismatch, m_sel_mis);
            chk("stream_seen", 32'(stream_seen), 32'(m_seen));
            chk("okay_led", 32'(okay_led), 32'(streak >= int'(MATCH)));
            chk("link_count_okay", 32'(link_count_okay), 32'(m_link));
        end
    end

    task automatic send(input logic [3:0] id, input logic [CW-1:0] cnt);
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        bus.packet_data          = r[87:0];
        bus.packet_data[83:80]   = id;
        bus.packet_data[CW-1:0]  = cnt;
        bus.packet_valid         = 1'b1;
        @(posedge clk_256M); #1;
        bus.packet_valid         = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.packet_valid = 1'b0;
        repeat (n) begin
            @(posedge clk_256M); #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    logic [3:0]  r_id;
    logic [CW-1:0] r_cnt;
    int          r_sel;

    initial begin
        bus.packet_data  = '0;
        bus.packet_valid = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        chk_en = 1'b1;
        chk("reset_total", total_packets, 32'd0);
        chk("reset_led", 32'(okay_led), 32'd0);

        // Stream 0xD seeding and in-order counts.
        send(4'hD, 10'd5);
        send(4'hD, 10'd6);
        chk("p1_link_n2", 32'(link_count_okay), 32'd1);
        send(4'hD, 10'd7);
        idle(1);
        chk("p1_checked", checked_packets, 32'd3);
        chk("p1_mismatch", mismatch_packets, 32'd0);
        chk("p1_seen", 32'(stream_seen), 32'h2000);

        // Counter wrap, then one dropped value.
        do_reset();
        send(4'hD, 10'd1022); send(4'hD, 10'd1023); send(4'hD, 10'd0); send(4'hD, 10'd1);
        idle(1);
        chk("p2_wrap_mismatch", mismatch_packets, 32'd0);
        send(4'hD, 10'd3);
        idle(1);
        chk("p2_drop_mismatch", mismatch_packets, 32'd1);
        chk("p2_drop_link", 32'(link_count_okay), 32'd0);
        send(4'hD, 10'd4);
        idle(1);
        chk("p2_resync_link", 32'(link_count_okay), 32'd1);

        // Interleaved streams 0 and 3, stat mux, disabled id 5.
        do_reset();
        send(4'h0, 10'd0); send(4'h3, 10'd100);
        send(4'h0, 10'd1); send(4'h3, 10'd101);
        send(4'h0, 10'd2); send(4'h3, 10'd150);
        stat_sel = 4'd3;
        idle(2);
        chk("p3_sel3_pkts", sel_packets, 32'd3);
        chk("p3_sel3_mis", sel_mismatch, 32'd1);
        stat_sel = 4'd0;
        idle(1);
        chk("p3_sel0_mis", sel_mismatch, 32'd0);
        chk("p3_sel0_pkts", sel_packets, 32'd3);
        send(4'h5, 10'd9); send(4'h5, 10'd77); send(4'h5, 10'd1);
        chk("p3_total", total_packets, 32'd9);
        chk("p3_checked", checked_packets, 32'd6);
        chk("p3_seen", 32'(stream_seen), 32'h0009);

        // Streak to UP, bad packet drops it.
        do_reset();
        send(4'hD, 10'd10); send(4'hD, 10'd11); send(4'hD, 10'd12); send(4'hD, 10'd13);
        chk("p4_led_before", 32'(okay_led), 32'd0);
        idle(1);
        chk("p4_led_up", 32'(okay_led), 32'd1);
        send(4'hD, 10'd20);
        idle(1);
        chk("p4_led_bad", 32'(okay_led), 32'd0);

        // Timeout while UP, then re-arming.
        send(4'hD, 10'd21); send(4'hD, 10'd22); send(4'hD, 10'd23); send(4'hD, 10'd24);
        idle(16);
        chk("p5_led_16idle", 32'(okay_led), 32'd1);
        chk("p5_link_16idle", 32'(link_count_okay), 32'd1);
        idle(1);
        chk("p5_led_timeout", 32'(okay_led), 32'd0);
        chk("p5_link_timeout", 32'(link_count_okay), 32'd0);
        send(4'hD, 10'd25);
        idle(1);
        chk("p5_rearm_link", 32'(link_count_okay), 32'd1);
        chk("p5_rearm_led", 32'(okay_led), 32'd0);

        // reset_counters against a same-cycle packet, then mid-stream reset.
        reset_counters = 1'b1;
        send(4'hD, 10'd26);
        reset_counters = 1'b0;
        chk("p6_rc_total", total_packets, 32'd0);
        chk("p6_rc_checked", checked_packets, 32'd0);
        idle(1);
        chk("p6_rc_mismatch", mismatch_packets, 32'd0);
        send(4'hD, 10'd27);
        rst_n = 1'b0;
        #1;
        chk("p6_rst_checked", checked_packets, 32'd0);
        chk("p6_rst_seen", 32'(stream_seen), 32'd0);
        chk("p6_rst_link", 32'(link_count_okay), 32'd0);
        @(posedge clk_256M); #1;
        rst_n = 1'b1;
        send(4'hD, 10'd500); send(4'hD, 10'd501);
        idle(2);
        chk("p6_reseed_mismatch", mismatch_packets, 32'd0);
        chk("p6_reseed_checked", checked_packets, 32'd2);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            if ((i % 500) == 250) idle(20);
            if ((i % 16) == 0) stat_sel = 4'($urandom_range(15, 0));
            reset_counters = ($urandom_range(99, 0) == 0);
            if ($urandom_range(1, 0) == 1) begin
                r_sel = int'($urandom_range(7, 0));
                if (r_sel < 3)      r_id = 4'h0;
                else if (r_sel < 5) r_id = 4'h3;
                else if (r_sel < 7) r_id = 4'hD;
                else                r_id = 4'($urandom_range(15, 0));
                if ($urandom_range(9, 0) != 0) r_cnt = m_exp[r_id];
                else                           r_cnt = CW'($urandom);
                send(r_id, r_cnt);
            end else begin
                idle(1);
            end
            reset_counters = 1'b0;
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/telemetry_check_multi.md
Name: telemetry_check_multi

Overview:
Parametrised successor to the single-stream counter checker. It checks incrementing test counters on up to 16 telemetry streams at once, selected by the class-id nibble of each packet. Statistics are kept per stream, with a first-packet seeding rule and saturating counters. The block sits on the unpacked telemetry packet bus in the clk_256M domain, alongside the telemetry test-counter generator, and drives the board LEDs and debug registers.

Parameters:
g_stream_mask, 16'h2000, bit n set = stream id n is checked; default checks stream 0xD only.
g_cnt_width, 10, counter field width in packet_data[g_cnt_width-1:0]; legal range 1..32.
g_match_cnt, 20'h4ffff, consecutive good checked packets before okay_led lights.
g_timeout_cnt, 16'hffff, idle cycles without packet_valid before both LEDs drop.
g_saturate, 1, 1 = statistics counters saturate at all-ones; 0 = statistics counters wrap.

Ports:
clk_256M  in  1  sole clock.
rst_n  in  1  asynchronous, active-low reset.
packet_data  in  88  packet; [83:80] = stream id, [g_cnt_width-1:0] = counter.
packet_valid  in  1  single-cycle qualifier for packet_data.
reset_counters  in  1  synchronous clear of statistics only.
stat_sel  in  4  stream index for sel_mismatch and sel_packets.
total_packets  out  32  all valid packets.
checked_packets  out  32  valid packets whose id is enabled in g_stream_mask.
mismatch_packets  out  32  sum of mismatches over all streams.
sel_packets  out  32  checked packets on stream stat_sel.
sel_mismatch  out  32  mismatches on stream stat_sel.
stream_seen  out  16  bit n = stream n has been seeded.
okay_led  out  1  long-streak good indicator.
link_count_okay  out  1  fast per-packet good indicator.

Behaviour:
- Reset (rst_n=0): all registers clear asynchronously. All outputs are 0, the LED FSM is in DOWN, and all seeded flags are 0.
- Enabled packet: packet_valid=1 and g_stream_mask[id]=1. All other valid packets only increment total_packets.
- Per-stream state for each enabled stream: expected[g_cnt_width-1:0], seen flag, pkt count [31:0], mismatch count [31:0]. Logic for disabled ids is optimised away.
- First enabled packet on a stream with seen=0:
  - sets seen and loads expected = cnt+1;
  - counts as a match; the mismatch count is not incremented.
- Subsequent packets:
  - cnt==expected gives a match;
  - otherwise the stream's mismatch count increments;
  - in both cases expected reloads to cnt+1, so the checker resyncs immediately.
- Counter arithmetic is modulo 2^g_cnt_width, so all-ones is followed by 0 with no mismatch.
- Latency:
  - statistics and stream_seen update on the edge after packet_valid (visible at N+1);
  - the match flag registers at N+1;
  - link_count_okay, okay_led and the FSM update at N+2.
- mismatch_packets is a registered adder over the per-stream counts, with one extra cycle of latency (visible at N+2). It saturates when g_saturate=1.
- sel_* outputs are a registered mux: a stat_sel change is visible after 1 cycle.
- reset_counters=1 clears every count to 0 and wins over a simultaneous increment. It does not clear expected, seen, or the LED FSM.
- Saturation: when g_saturate=1, every 32-bit count holds at 32'hffffffff; when g_saturate=0 the counts wrap.
- LED FSM, states DOWN, ARMING, UP; the match counter is [19:0].
  - DOWN: on a registered match go to ARMING with match counter = 1.
  - ARMING: on a match, increment the match counter. When the counter is >= g_match_cnt on a match, go to UP.
  - UP: okay_led=1.
  - Any registered mismatch in any state: go to DOWN and clear the match counter.
  - Timeout counter [15:0]: cleared on packet_valid, otherwise increments. When it equals g_timeout_cnt, go to DOWN and clear link_count_okay. The counter then wraps and keeps counting.
  - link_count_okay: set to 1 on a match, 0 on a mismatch, and 0 on timeout.
- Non-enabled valid packets clear the timeout counter but never change match, FSM or link_count_okay.
- Only one packet can arrive per cycle, so there are no simultaneous stream updates.

Decomposition:
- Package telemetry_check_pkg holds:
  - packet field constants: ID_MSB=83, ID_LSB=80, PKT_W=88;
  - the FSM state encoding (DOWN=0, ARMING=1, UP=2);
  - a saturating-increment function.
- Sub-module telemetry_stream_check: one instance per stream via generate. It holds expected, seen, pkt count and mismatch count, and outputs match/mismatch strobes.
- The top level holds the totals, the stat mux, the adder, the FSM and the timeout logic.

Test Plan:
1. Reset, then stream 0xD counts 5,6,7 → checked_packets=3, mismatch_packets=0, stream_seen[13]=1, link_count_okay=1 at N+2 of the 1st packet.
2. Stream 0xD with g_cnt_width=10 sends 1022,1023,0,1 → 0 mismatches; then 3 (dropped 2) → mismatch_packets=1; then 4 → link_count_okay back to 1.
3. g_stream_mask=16'h0009, alternating id 0 (0,1,2) and id 3 (100,101,150); stat_sel=3 → sel_packets=3, sel_mismatch=1; stat_sel=0 → sel_mismatch=0; id 5 packets raise total_packets only.
4. g_match_cnt=4, 4 good packets → okay_led=1 two cycles after the 4th; one bad packet → okay_led=0 at N+2.
5. g_timeout_cnt=16, packets stop while UP → both LEDs go 0 on the 17th idle cycle; the next good packet gives ARMING, not UP.
6. reset_counters asserted with packet_valid in the same cycle → counts read 0. Assert rst_n=0 mid-stream → all outputs 0 immediately; the next packet seeds with no mismatch.
